// File: rtl/laser310_pkg.sv
// Shared types and constants for the VZ image loader of the Laser310 core.
// Latency: n/a, this file only holds declarations.
// Backpressure: n/a.
package laser310_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      DATA,
      PATCH_LO,
      PATCH_HI,
      DONE,
      DRAIN
   } vz_state_t;

   localparam int          VZ_HDR_LEN    = 24;
   localparam logic [7:0]  VZ_TYPE_BASIC = 8'hF0;
   localparam logic [7:0]  VZ_TYPE_MCODE = 8'hF1;

   // Header magic words, first file byte in the top byte.
   localparam logic [31:0] VZ_MAGIC_A    = 32'h565A_4630;  // "VZF0"
   localparam logic [31:0] VZ_MAGIC_B    = 32'h5645_5A46;  // "VEZF"

   // One buffered download byte together with its file offset.
   typedef struct packed {
      logic [15:0] addr;
      logic [7:0]  dat;
   } vz_entry_t;

   // Magic byte expected at header offset idx (0..3).
   function automatic logic [7:0] magic_byte(input logic [31:0] word, input logic [1:0] idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = word[31:24];
         2'd1:    b = word[23:16];
         2'd2:    b = word[15:8];
         default: b = word[7:0];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/vz_loader_if.sv
// Download-port and RAM-write-port bundle between hps_io, the loader and the arbiter.
// Latency: n/a, wiring only.
// Backpressure: dn_wait pauses the download side, ram_ack completes each RAM write.
interface vz_loader_if;
   logic        dn_download;
   logic        dn_wr;
   logic [15:0] dn_addr;
   logic [7:0]  dn_data;
   logic [7:0]  dn_index;
   logic        dn_wait;
   logic [15:0] ram_addr;
   logic [7:0]  ram_data;
   logic        ram_req;
   logic        ram_ack;

   // Environment side: HPS download source plus memory arbiter.
   modport master (
      output dn_download, dn_wr, dn_addr, dn_data, dn_index, ram_ack,
      input  dn_wait, ram_addr, ram_data, ram_req
   );

   // Loader side.
   modport slave (
      input  dn_download, dn_wr, dn_addr, dn_data, dn_index, ram_ack,
      output dn_wait, ram_addr, ram_data, ram_req
   );
endinterface

// File: rtl/vz_byte_fifo.sv
// Synchronous FIFO of {file offset, byte} decoupling the HPS download from RAM writes.
// Latency: a pushed entry is visible at head_o the cycle after the push.
// Backpressure: push is ignored while full_o, pop is ignored while empty_o.
module vz_byte_fifo
   import laser310_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic      clk_i,
   input  logic      rst_n_i,
   input  logic      push_i,
   input  vz_entry_t push_dat_i,
   input  logic      pop_i,
   output vz_entry_t head_o,
   output logic      full_o,
   output logic      empty_o
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;

   vz_entry_t         mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q;
   logic [AW-1:0]     rd_ptr_q;
   logic [CW-1:0]     cnt_q;
   logic              push_ok;
   logic              pop_ok;

   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;
   assign head_o  = mem_q[rd_ptr_q];

   // Storage, pointers and occupancy; depth is a power of two so pointers wrap naturally.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q] <= push_dat_i;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (pop_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end
endmodule

// File: rtl/vz_loader.sv
// Turns an HPS .VZ download into Z80 RAM writes and patches the BASIC-end or USR pointer.
// Latency: a byte offered to an empty FIFO raises ram_req 2 cycles after its dn_wr cycle.
// Backpressure: dn_wait while the byte FIFO is full; each RAM write holds ram_req until ram_ack.
module vz_loader
   import laser310_pkg::*;
#(
   parameter logic [7:0]  VZ_INDEX      = 8'd1,
   parameter int          FIFO_DEPTH    = 4,
   parameter logic [15:0] BASIC_END_PTR = 16'h78F9,
   parameter logic [15:0] USR_PTR       = 16'h788E
) (
   input  logic       CLK42MHZ,
   input  logic       RESET,
   vz_loader_if.slave bus,
   output logic       cpu_hold,
   output logic       load_done,
   output logic       load_err,
   output logic       load_ovf
);
   vz_state_t   state_q;
   logic        dl_q;
   logic        ram_req_q;
   logic [15:0] ram_addr_q;
   logic [7:0]  ram_data_q;
   logic        cpu_hold_q;
   logic        load_done_q;
   logic        load_err_q;
   logic        load_ovf_q;
   logic        written_q;
   logic        mag_a_q;
   logic        mag_b_q;
   logic [7:0]  type_q;
   logic [15:0] start_q;
   logic [15:0] end_q;

   logic        sel;
   logic        push;
   logic        pop;
   logic        rise;
   logic        fifo_full;
   logic        fifo_empty;
   vz_entry_t   in_ent;
   vz_entry_t   head;
   logic [16:0] tgt_d;
   logic [15:0] end_d;
   logic        mag_a_d;
   logic        mag_b_d;
   logic [15:0] patch_ptr;
   logic [15:0] patch_val;

   assign sel         = (bus.dn_index == VZ_INDEX);
   assign push        = bus.dn_download & bus.dn_wr & sel;
   assign rise        = bus.dn_download & ~dl_q & sel;
   assign in_ent.addr = bus.dn_addr;
   assign in_ent.dat  = bus.dn_data;

   vz_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i      (CLK42MHZ),
      .rst_n_i    (RESET),
      .push_i     (push),
      .push_dat_i (in_ent),
      .pop_i      (pop),
      .head_o     (head),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty)
   );

   // Target address is 17 bits wide so a payload running past FFFF is detectable.
   assign tgt_d     = {1'b0, start_q} + {1'b0, head.addr} - 17'(VZ_HDR_LEN);
   assign end_d     = (tgt_d[15:0] == 16'hFFFF) ? 16'hFFFF : tgt_d[15:0] + 16'd1;
   assign mag_a_d   = mag_a_q & (head.dat == magic_byte(VZ_MAGIC_A, head.addr[1:0]));
   assign mag_b_d   = mag_b_q & (head.dat == magic_byte(VZ_MAGIC_B, head.addr[1:0]));
   assign patch_ptr = (type_q == VZ_TYPE_BASIC) ? BASIC_END_PTR : USR_PTR;
   assign patch_val = (type_q == VZ_TYPE_BASIC) ? end_q : start_q;

   // Pop one entry per cycle; IDLE flushes bytes of ignored downloads, DATA waits for the write to finish.
   always_comb begin
      pop = 1'b0;
      case (state_q)
         IDLE, HDR, DRAIN: pop = ~fifo_empty;
         DATA:             pop = ~fifo_empty & ~ram_req_q;
         default:          pop = 1'b0;
      endcase
   end

   // Load sequencer with registered RAM-port and status outputs.
   always_ff @(posedge CLK42MHZ or negedge RESET) begin
      if (!RESET) begin
         state_q     <= IDLE;
         dl_q        <= 1'b0;
         ram_req_q   <= 1'b0;
         ram_addr_q  <= '0;
         ram_data_q  <= '0;
         cpu_hold_q  <= 1'b0;
         load_done_q <= 1'b0;
         load_err_q  <= 1'b0;
         load_ovf_q  <= 1'b0;
         written_q   <= 1'b0;
         mag_a_q     <= 1'b0;
         mag_b_q     <= 1'b0;
         type_q      <= '0;
         start_q     <= '0;
         end_q       <= '0;
      end else begin
         dl_q        <= bus.dn_download;
         load_done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (rise) begin
                  state_q    <= HDR;
                  cpu_hold_q <= 1'b1;
                  load_err_q <= 1'b0;
                  load_ovf_q <= 1'b0;
                  written_q  <= 1'b0;
                  mag_a_q    <= 1'b1;
                  mag_b_q    <= 1'b1;
                  type_q     <= '0;
                  start_q    <= '0;
                  end_q      <= '0;
               end
            end
            HDR: begin
               if (!fifo_empty) begin
                  if (head.addr < 16'd4) begin
                     mag_a_q <= mag_a_d;
                     mag_b_q <= mag_b_d;
                     if (!mag_a_d && !mag_b_d) begin
                        load_err_q <= 1'b1;
                        state_q    <= DRAIN;
                     end
                  end else if (head.addr == 16'd21) begin
                     type_q <= head.dat;
                     if (head.dat != VZ_TYPE_BASIC && head.dat != VZ_TYPE_MCODE) begin
                        load_err_q <= 1'b1;
                        state_q    <= DRAIN;
                     end
                  end else if (head.addr == 16'd22) begin
                     start_q[7:0] <= head.dat;
                  end else if (head.addr == 16'd23) begin
                     start_q[15:8] <= head.dat;
                     state_q       <= DATA;
                  end else if (head.addr >= 16'(VZ_HDR_LEN)) begin
                     // Payload before a complete header: offset 23 never arrived.
                     load_err_q <= 1'b1;
                     state_q    <= DRAIN;
                  end
               end else if (!bus.dn_download) begin
                  // File ended inside the header.
                  load_err_q <= 1'b1;
                  state_q    <= DRAIN;
               end
            end
            DATA: begin
               if (ram_req_q) begin
                  if (bus.ram_ack) ram_req_q <= 1'b0;
               end else if (!fifo_empty) begin
                  if (head.addr >= 16'(VZ_HDR_LEN)) begin
                     if (tgt_d[16]) begin
                        load_ovf_q <= 1'b1;
                     end else begin
                        ram_addr_q <= tgt_d[15:0];
                        ram_data_q <= head.dat;
                        ram_req_q  <= 1'b1;
                        written_q  <= 1'b1;
                        end_q      <= end_d;
                     end
                  end
               end else if (!bus.dn_download) begin
                  if (written_q) begin
                     state_q    <= PATCH_LO;
                     ram_addr_q <= patch_ptr;
                     ram_data_q <= patch_val[7:0];
                     ram_req_q  <= 1'b1;
                  end else begin
                     state_q     <= DONE;
                     load_done_q <= 1'b1;
                  end
               end
            end
            PATCH_LO: begin
               // Request stays high: the high-byte write follows straight after the ack.
               if (bus.ram_ack) begin
                  state_q    <= PATCH_HI;
                  ram_addr_q <= patch_ptr + 16'd1;
                  ram_data_q <= patch_val[15:8];
               end
            end
            PATCH_HI: begin
               if (bus.ram_ack) begin
                  state_q     <= DONE;
                  ram_req_q   <= 1'b0;
                  load_done_q <= 1'b1;
               end
            end
            DONE: begin
               cpu_hold_q <= 1'b0;
               state_q    <= IDLE;
            end
            DRAIN: begin
               if (!bus.dn_download && fifo_empty) begin
                  cpu_hold_q <= 1'b0;
                  state_q    <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.dn_wait  = fifo_full;
   assign bus.ram_addr = ram_addr_q;
   assign bus.ram_data = ram_data_q;
   assign bus.ram_req  = ram_req_q;
   assign cpu_hold     = cpu_hold_q;
   assign load_done    = load_done_q;
   assign load_err     = load_err_q;
   assign load_ovf     = load_ovf_q;
endmodule

// File: doc/vz_loader.md
Name: vz_loader

Overview:
- Converts the HPS file-download byte stream (.VZ images, OSD menu entry F1) into Z80 RAM writes for the Laser310 core.
- Sits between the hps_io download port and the core's memory arbiter.
- Parses the 24-byte VZ header and stores the payload at the header's start address.
- After the payload, patches the system pointers so the program can be RUN (BASIC) or called through USR (machine code).
- Holds the CPU for the whole load.

Parameters:
- VZ_INDEX, 8'd1, dn_index value that selects VZ images; any other index is ignored.
- FIFO_DEPTH, 4, number of entries in the byte buffer between the download and RAM sides; power of two, at least 2.
- BASIC_END_PTR, 16'h78F9, address of the little-endian end-of-BASIC pointer, patched for type F0.
- USR_PTR, 16'h788E, address of the little-endian USR vector, patched for type F1.

Ports:
- CLK42MHZ  in  1  system clock.
- RESET  in  1  asynchronous, active-low reset.
- dn_download  in  1  download active.
- dn_wr  in  1  one-cycle byte strobe.
- dn_addr  in  16  file byte offset.
- dn_data  in  8  file byte.
- dn_index  in  8  menu index.
- dn_wait  out  1  asks HPS to pause; asserted when the FIFO is full.
- ram_addr  out  16  write address.
- ram_data  out  8  write data.
- ram_req  out  1  write request, level.
- ram_ack  in  1  one-cycle accept from the arbiter.
- cpu_hold  out  1  stalls the Z80.
- load_done  out  1  one-cycle pulse on successful completion.
- load_err  out  1  sticky: bad magic or unknown type.
- load_ovf  out  1  sticky: payload passed 16'hFFFF.

Behaviour:
- Reset values: all outputs 0; FIFO empty; state IDLE; internal registers cleared.
- A byte is accepted only when dn_download=1, dn_wr=1 and dn_index==VZ_INDEX. Accepted bytes are pushed into the FIFO together with their dn_addr.
- dn_wait = FIFO full.
  - A dn_wr that arrives while the FIFO is full is dropped.
  - A bench violation flag (sim only) records the drop.
- The FIFO is popped by the state machine, at most one entry per cycle.
- States:
  - IDLE: on rising edge of dn_download with the selected index → HDR. cpu_hold=1, load_err and load_ovf cleared.
  - HDR: consumes offsets 0..23.
    - Offsets 0-3 are checked against "VZF0" or "VEZF". A mismatch sets load_err and goes to DRAIN.
    - Offsets 4-20 (name) are discarded.
    - Offset 21 is latched as type. Any value other than F0 or F1 sets load_err and goes to DRAIN.
    - Offsets 22/23 are latched as start low/high.
    - After offset 23 → DATA. The current address is initialised to start.
  - DATA: for each popped byte, drive ram_addr=start+(dn_addr-24), ram_data=byte, ram_req=1, and hold until ram_ack.
    - There is exactly one write per byte and no pop while ram_req is high.
    - If start+(dn_addr-24) > 16'hFFFF: no write, load_ovf set, byte discarded.
    - The last written address + 1 is tracked as end (17-bit, saturated to 16'hFFFF).
    - When dn_download falls and the FIFO is empty → PATCH_LO. If no data byte was written, go to DONE without patching.
  - PATCH_LO / PATCH_HI: write the low and high byte of the patch value using the same req/ack handshake.
    - Type F0: target BASIC_END_PTR and BASIC_END_PTR+1, value end.
    - Type F1: target USR_PTR and USR_PTR+1, value start.
  - DONE: one-cycle load_done pulse (not pulsed in the error path), cpu_hold falls the next cycle → IDLE.
  - DRAIN: pop and discard everything until dn_download=0 and the FIFO is empty, then → IDLE. cpu_hold is released on exit and load_err stays set.
- Header bytes are identified by dn_addr, not by arrival count. A file shorter than 24 bytes ends in DRAIN with load_err set.
- A new download starting in a non-IDLE state is ignored until IDLE is reached. dn_wait still protects the FIFO during that time.
- Asynchronous reset mid-load aborts immediately: ram_req=0, cpu_hold=0, no patch is written.
- Latency: a byte offered to an empty FIFO reaches ram_req 2 cycles after the dn_wr cycle.

Decomposition:
- Shared package laser310_pkg holds:
  - vz_state_t enum (IDLE, HDR, DATA, PATCH_LO, PATCH_HI, DONE, DRAIN);
  - constants VZ_HDR_LEN=24, VZ_TYPE_BASIC=8'hF0, VZ_TYPE_MCODE=8'hF1;
  - the two magic words.
- One sub-module: vz_byte_fifo, a synchronous FIFO of {addr[15:0], data[7:0]} with full/empty flags, same clock and reset.

Test Plan:
- BASIC image: "VZF0", type F0, start 7AE9, 16 payload bytes, ack after 1 cycle → 16 writes at 7AE9..7AF8, then 78F9=F9, 78FA=7A, one load_done pulse, cpu_hold high throughout.
- Machine code: type F1, start 8000, 3 bytes → writes 8000..8002, then 788E=00, 788F=80.
- Backpressure: ram_ack delayed 10 cycles, dn_wr every cycle → dn_wait asserts at 4 entries, no byte lost, all writes in order.
- Bad magic "ABCD" → no RAM writes, load_err=1, load_done never pulses, cpu_hold drops after dn_download falls.
- Overflow: start FFFE, 4 bytes → writes FFFE/FFFF only, load_ovf=1; 78F9=FF, 78FA=FF.
- Reset asserted during DATA → all outputs 0 within the same cycle, no patch writes; wrong dn_index=0 download produces no activity.
